imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: receives a byte stream (boot/debug link),

---
 rtl/imem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot/debug-link instruction memory loader. Accepts a byte
//               stream, packs bytes little-endian (first byte = LSB) into
//               32-bit words and writes them to consecutive instruction
//               memory words through a single write port. Keeps the core in
//               reset (cpu_hold_o) until an image has loaded correctly.
// Config      : IMEM_LOADER_CHECKSUM_EN - when defined, a trailing 4-byte
//               checksum word is received after the last data word and
//               compared against the XOR of all written words.
// Ports       : clk_i          rising-edge clock
//               reset_i        synchronous active-high reset
//               start_i        1-cycle start pulse, word_count_i sampled with it
//               word_count_i   number of 32-bit words in the image
//               rx_data_i      stream byte
//               rx_valid_i     stream byte valid
//               rx_ready_o     loader accepts a byte this cycle
//               mem_we_o       memory write strobe, one cycle per word
//               mem_addr_o     byte address of the word written
//               mem_wdata_o    word written
//               busy_o         load in progress
//               done_o         load finished (good or bad), sticky
//               error_o        load failed, meaningful while done_o = 1
//               cpu_hold_o     1 = keep core in reset
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             cpu_hold_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    state_t             r_state_q;
    logic [CNT_W-1:0]   r_count_q;
    logic [CNT_W-1:0]   r_word_idx_q;
    logic [1:0]         r_byte_idx_q;
    logic [23:0]        r_shift_q;      // bytes 0..2 of the word being assembled
    logic               r_rx_ready_q;
    logic               r_mem_we_q;
    logic [31:0]        r_mem_addr_q;
    logic [31:0]        r_mem_wdata_q;
    logic               r_busy_q;
    logic               r_done_q;
    logic               r_error_q;
    logic               r_cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]        r_xor_q;
`endif

    logic               w_xfer;
    logic [31:0]        w_word;
    logic               w_count_ok;
    logic               w_last_word;

    assign w_xfer      = rx_valid_i & r_rx_ready_q;
    // Complete word as it stands once the current byte lands in the top lane.
    assign w_word      = {rx_data_i, r_shift_q};
    // Rejecting counts above DEPTH is what keeps the address from wrapping.
    assign w_count_ok  = (word_count_i != '0) && (word_count_i <= c_DEPTH);
    assign w_last_word = (r_word_idx_q == (r_count_q - c_ONE));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_q     <= S_IDLE;
            r_count_q     <= '0;
            r_word_idx_q  <= '0;
            r_byte_idx_q  <= '0;
            r_shift_q     <= '0;
            r_rx_ready_q  <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_error_q     <= 1'b0;
            r_cpu_hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor_q       <= '0;
`endif
        end else begin
            case (r_state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        if (!w_count_ok) begin
                            r_state_q    <= S_DONE;
                            r_busy_q     <= 1'b0;
                            r_done_q     <= 1'b1;
                            r_error_q    <= 1'b1;
                            r_cpu_hold_q <= 1'b1;
                        end else begin
                            r_state_q    <= S_RECV;
                            r_count_q    <= word_count_i;
                            r_word_idx_q <= '0;
                            r_byte_idx_q <= '0;
                            r_shift_q    <= '0;
                            r_rx_ready_q <= 1'b1;
                            r_busy_q     <= 1'b1;
                            r_done_q     <= 1'b0;
                            r_error_q    <= 1'b0;
                            r_cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_xor_q      <= '0;
`endif
                        end
                    end
                end

                S_RECV: begin
                    if (w_xfer) begin
                        r_shift_q    <= {rx_data_i, r_shift_q[23:8]};
                        r_byte_idx_q <= r_byte_idx_q + 2'd1;
                        if (r_byte_idx_q == 2'd3) begin
                            r_state_q     <= S_WRITE;
                            r_rx_ready_q  <= 1'b0;
                            r_mem_we_q    <= 1'b1;
                            r_mem_addr_q  <= 32'({r_word_idx_q, 2'b00});
                            r_mem_wdata_q <= w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_xor_q       <= r_xor_q ^ w_word;
`endif
                        end
                    end
                end

                S_WRITE: begin
                    r_mem_we_q   <= 1'b0;
                    r_byte_idx_q <= '0;
                    if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state_q    <= S_CHECK;
                        r_rx_ready_q <= 1'b1;
`else
                        r_state_q    <= S_DONE;
                        r_busy_q     <= 1'b0;
                        r_done_q     <= 1'b1;
                        r_cpu_hold_q <= r_error_q;
`endif
                    end else begin
                        r_state_q    <= S_RECV;
                        r_word_idx_q <= r_word_idx_q + c_ONE;
                        r_rx_ready_q <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        r_shift_q    <= {rx_data_i, r_shift_q[23:8]};
                        r_byte_idx_q <= r_byte_idx_q + 2'd1;
                        if (r_byte_idx_q == 2'd3) begin
                            r_state_q    <= S_DONE;
                            r_rx_ready_q <= 1'b0;
                            r_busy_q     <= 1'b0;
                            r_done_q     <= 1'b1;
                            r_error_q    <= (w_word != r_xor_q);
                            r_cpu_hold_q <= (w_word != r_xor_q);
                        end
                    end
                end
`endif

                default: begin
                    r_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready_o  = r_rx_ready_q;
    assign mem_we_o    = r_mem_we_q;
    assign mem_addr_o  = r_mem_addr_q;
    assign mem_wdata_o = r_mem_wdata_q;
    assign busy_o      = r_busy_q;
    assign done_o      = r_done_q;
    assign error_o     = r_error_q;
    assign cpu_hold_o  = r_cpu_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. The stimulus side drives
//               random images and pushes the expected memory writes; a
//               separate monitor pops and compares on every mem_we_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int CNT_W = 9;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             busy_o;
    logic             done_o;
    logic             error_o;
    logic             cpu_hold_o;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .word_count_i (word_count),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .cpu_hold_o   (cpu_hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          wcyc[$];
    int          nwr    = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] words[0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected write, land in the
    // cycle right after its 4th byte was accepted, and never coincide with rx_ready.
    exp_t e_mon;
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we_o === 1'b1) begin
            nwr++;
            wcyc.push_back(pcyc);
            chk("rx_ready_during_write", {31'd0, rx_ready_o}, 32'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o, mem_wdata_o);
            end else begin
                e_mon = sb_q.pop_front();
                chk("write_addr", mem_addr_o, e_mon.addr);
                chk("write_data", mem_wdata_o, e_mon.data);
                chk("write_latency_cycle", pcyc, e_mon.cyc);
            end
        end
    end

    task automatic pulse_start(input int n);
        @(negedge clk);
        start      = 1'b1;
        word_count = CNT_W'(n);
        @(posedge clk);
        #1 start   = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles, holds it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready_o !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got rx_ready %b expected 1", rx_ready_o);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Reference: word i lands at byte address 4*i; byte k of the stream for
    // word i is (word >> 8k) mod 256; error only on a wrong checksum.
    task automatic do_load(input int n, input int maxgap, input bit bad_cs, input bit inject_start);
        logic [31:0] cs;
        int          t;
        bit          exp_err;
        pulse_start(n);
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy_o}, 32'd1);
        chk("hold_during_load", {31'd0, cpu_hold_o}, 32'd1);
        chk("done_cleared", {31'd0, done_o}, 32'd0);
        cs = '0;
        for (int i = 0; i < n; i++) begin
            cs = cs ^ words[i];
            for (int k = 0; k < 4; k++) begin
                if (inject_start && i == 0 && k == 2) pulse_start(5);
                send_byte(8'((words[i] >> (8 * k)) & 32'hFF), (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
            end
            sb_q.push_back('{addr: 32'(i * 4), data: words[i], cyc: pcyc});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (bad_cs) cs = cs + 32'd1;
        for (int k = 0; k < 4; k++) send_byte(8'((cs >> (8 * k)) & 32'hFF), 0);
        exp_err = bad_cs;
`else
        exp_err = 1'b0;
`endif
        t = 0;
        while (done_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_at_end", {31'd0, done_o}, 32'd1);
        chk("busy_at_end", {31'd0, busy_o}, 32'd0);
        chk("error_at_end", {31'd0, error_o}, {31'd0, exp_err});
        chk("cpu_hold_at_end", {31'd0, cpu_hold_o}, {31'd0, exp_err});
        chk("pending_writes", sb_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int w0;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        word_count = '0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_error", {31'd0, error_o}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold_o}, 32'd1);
        reset = 1'b0;

        // 1: single word 13 00 00 00
        words[0] = 32'h0000_0013;
        do_load(1, 0, 1'b0, 1'b0);

        // 2: three words back to back, writes exactly 5 cycles apart
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        base = wcyc.size();
        do_load(3, 0, 1'b0, 1'b0);
        if (wcyc.size() >= base + 3) begin
            chk("write_spacing_0_1", wcyc[base + 1] - wcyc[base], 32'd5);
            chk("write_spacing_1_2", wcyc[base + 2] - wcyc[base + 1], 32'd5);
        end else begin
            chk("write_count_test2", wcyc.size() - base, 32'd3);
        end

        // 3: two words with valid gaps 0..7, stray start pulse mid-load
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        do_load(2, 7, 1'b0, 1'b1);

        // 4: invalid counts
        foreach (words[i]) words[i] = words[i];
        w0 = nwr;
        pulse_start(0);
        repeat (3) @(negedge clk);
        chk("cnt0_done", {31'd0, done_o}, 32'd1);
        chk("cnt0_error", {31'd0, error_o}, 32'd1);
        chk("cnt0_hold", {31'd0, cpu_hold_o}, 32'd1);
        chk("cnt0_busy", {31'd0, busy_o}, 32'd0);
        pulse_start(DEPTH + 1);
        repeat (3) @(negedge clk);
        chk("cnt257_done", {31'd0, done_o}, 32'd1);
        chk("cnt257_error", {31'd0, error_o}, 32'd1);
        chk("cnt257_hold", {31'd0, cpu_hold_o}, 32'd1);
        chk("invalid_no_writes", nwr - w0, 32'd0);

        // 5: reset after the second word of a four-word load
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        pulse_start(4);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) send_byte(8'((words[i] >> (8 * k)) & 32'hFF), 0);
            sb_q.push_back('{addr: 32'(i * 4), data: words[i], cyc: pcyc});
        end
        send_byte(8'hA5, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_hold", {31'd0, cpu_hold_o}, 32'd1);
        chk("midrst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        w0 = nwr;
        repeat (10) @(negedge clk);
        chk("midrst_no_writes", nwr - w0, 32'd0);
        chk("midrst_pending", sb_q.size(), 32'd0);
        do_load(4, 2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum good then bad
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        w0 = nwr;
        do_load(2, 0, 1'b0, 1'b0);
        chk("cs_good_writes", nwr - w0, 32'd2);
        w0 = nwr;
        do_load(2, 0, 1'b1, 1'b0);
        chk("cs_bad_writes", nwr - w0, 32'd2);
`endif

        // Random loads
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            do_load(n, 3, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("final_pending", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
